// File: rtl/parking_gate_ctrl.sv
// Car-park entrance gate controller: password FSM with retry lockout, occupancy counter, 7-seg status.
// Build macro OCCUPANCY_DISPLAY_EN adds a decimal occupancy readout while the lane is idle.
module parking_gate_ctrl #(
    parameter int                  PW_WIDTH    = 2,
    parameter logic [PW_WIDTH-1:0] PASS_1      = 2'b01,
    parameter logic [PW_WIDTH-1:0] PASS_2      = 2'b10,
    parameter int                  CAPACITY    = 8,
    parameter int                  CNT_W       = 7,
    parameter int                  WAIT_CYCLES = 3,
    parameter int                  MAX_TRIES   = 3,
    parameter int                  LOCK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sensor_entrance,
    input  logic                sensor_exit,
    input  logic                car_departed,
    input  logic [PW_WIDTH-1:0] password_1,
    input  logic [PW_WIDTH-1:0] password_2,
    output logic                GREEN_LED,
    output logic                RED_LED,
    output logic [6:0]          HEX_1,
    output logic [6:0]          HEX_2,
    output logic [CNT_W-1:0]    occupancy,
    output logic                full,
    output logic                lockout
);

    localparam int TMR_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TRY_W-1:0] TRY_LAST  = TRY_W'(MAX_TRIES - 1);
    localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

    localparam logic [6:0] GLY_E     = 7'b0000110;
    localparam logic [6:0] GLY_N     = 7'b0101011;
    localparam logic [6:0] GLY_G     = 7'b0000010;
    localparam logic [6:0] GLY_O     = 7'b1000000;
    localparam logic [6:0] GLY_S     = 7'b0010010;
    localparam logic [6:0] GLY_P     = 7'b0001100;
    localparam logic [6:0] GLY_F     = 7'b0001110;
    localparam logic [6:0] GLY_L     = 7'b1000111;
    localparam logic [6:0] GLY_BLANK = 7'b1111111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_WRONG = 3'd2,
        S_RIGHT = 3'd3,
        S_STOP  = 3'd4,
        S_LOCK  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [TRY_W-1:0]   try_q, try_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic               green_q, green_d;
    logic               red_q, red_d;
    logic               lock_q, lock_d;
    logic [6:0]         hex1_q, hex1_d;
    logic [6:0]         hex2_q, hex2_d;

    logic               pw_match;
    logic               admit;
    logic               depart;

    assign pw_match = (password_1 == PASS_1) && (password_2 == PASS_2);
    assign full     = (occ_q == CAP_VAL);

    // A departure reported at zero occupancy is a spurious pulse and is dropped.
    assign admit  = (state_q == S_RIGHT) && sensor_exit;
    assign depart = car_departed && (occ_q != '0);

    always_comb begin
        occ_d = occ_q;
        if (admit && !depart) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!admit && depart) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

`ifdef OCCUPANCY_DISPLAY_EN
    function automatic logic [6:0] digit_seg(input logic [CNT_W-1:0] d);
        case (d)
            CNT_W'(0): digit_seg = 7'b1000000;
            CNT_W'(1): digit_seg = 7'b1111001;
            CNT_W'(2): digit_seg = 7'b0100100;
            CNT_W'(3): digit_seg = 7'b0110000;
            CNT_W'(4): digit_seg = 7'b0011001;
            CNT_W'(5): digit_seg = 7'b0010010;
            CNT_W'(6): digit_seg = 7'b0000010;
            CNT_W'(7): digit_seg = 7'b1111000;
            CNT_W'(8): digit_seg = 7'b0000000;
            CNT_W'(9): digit_seg = 7'b0010000;
            default:   digit_seg = GLY_BLANK;
        endcase
    endfunction

    logic [CNT_W-1:0] occ_tens, occ_ones;
    logic [6:0]       occ_tens_seg, occ_ones_seg;

    always_comb begin
        occ_tens     = occ_d / CNT_W'(10);
        occ_ones     = occ_d % CNT_W'(10);
        occ_tens_seg = (occ_tens == '0) ? GLY_BLANK : digit_seg(occ_tens);
        occ_ones_seg = digit_seg(occ_ones);
    end
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            try_q   <= '0;
            occ_q   <= '0;
            green_q <= 1'b0;
            red_q   <= 1'b0;
            lock_q  <= 1'b0;
            hex1_q  <= GLY_BLANK;
            hex2_q  <= GLY_BLANK;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            try_q   <= try_d;
            occ_q   <= occ_d;
            green_q <= green_d;
            red_q   <= red_d;
            lock_q  <= lock_d;
            hex1_q  <= hex1_d;
            hex2_q  <= hex2_d;
        end
    end

    // Password states share one evaluation rule; only the display differs between them.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        try_d   = try_q;
        case (state_q)
            S_IDLE: begin
                if (sensor_entrance && !full) begin
                    state_d = S_WAIT;
                    tmr_d   = '0;
                end
            end
            S_WAIT, S_WRONG, S_STOP: begin
                if (tmr_q == WAIT_LAST) begin
                    tmr_d = '0;
                    if (pw_match) begin
                        state_d = S_RIGHT;
                        try_d   = '0;
                    end else begin
                        try_d   = try_q + TRY_W'(1);
                        state_d = (try_q == TRY_LAST) ? S_LOCK : S_WRONG;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_RIGHT: begin
                if (sensor_exit) begin
                    if (!sensor_entrance || (occ_d == CAP_VAL)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STOP;
                        tmr_d   = '0;
                    end
                end
            end
            S_LOCK: begin
                if (tmr_q == LOCK_LAST) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                    try_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
                try_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they line up with the state register.
    always_comb begin
        green_d = 1'b0;
        red_d   = 1'b0;
        lock_d  = 1'b0;
        hex1_d  = GLY_BLANK;
        hex2_d  = GLY_BLANK;
        case (state_d)
            S_IDLE: begin
                if (sensor_entrance && full) begin
                    red_d  = 1'b1;
                    hex1_d = GLY_F;
                    hex2_d = GLY_L;
                end
`ifdef OCCUPANCY_DISPLAY_EN
                else begin
                    hex1_d = occ_tens_seg;
                    hex2_d = occ_ones_seg;
                end
`endif
            end
            S_WAIT: begin
                hex1_d = GLY_E;
                hex2_d = GLY_N;
            end
            S_WRONG: begin
                red_d  = 1'b1;
                hex1_d = GLY_E;
                hex2_d = GLY_E;
            end
            S_RIGHT: begin
                green_d = 1'b1;
                hex1_d  = GLY_G;
                hex2_d  = GLY_O;
            end
            S_STOP: begin
                red_d  = 1'b1;
                hex1_d = GLY_S;
                hex2_d = GLY_P;
            end
            S_LOCK: begin
                red_d  = 1'b1;
                lock_d = 1'b1;
                hex1_d = GLY_L;
                hex2_d = GLY_O;
            end
            default: begin
                hex1_d = GLY_BLANK;
                hex2_d = GLY_BLANK;
            end
        endcase
    end

    assign GREEN_LED = green_q;
    assign RED_LED   = red_q;
    assign lockout   = lock_q;
    assign HEX_1     = hex1_q;
    assign HEX_2     = hex2_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: vector table, directed corner sequences, and a random run
// compared every cycle against a behavioural model of the gate rules.
`timescale 1ns/1ps
module tb_parking_gate_ctrl;

    localparam int CAP   = 8;
    localparam int WAITC = 3;
    localparam int TRIES = 3;
    localparam int LOCKC = 16;

    localparam logic [1:0] PW1 = 2'b01;
    localparam logic [1:0] PW2 = 2'b10;

    localparam logic [6:0] H_E = 7'b0000110;
    localparam logic [6:0] H_N = 7'b0101011;
    localparam logic [6:0] H_G = 7'b0000010;
    localparam logic [6:0] H_O = 7'b1000000;
    localparam logic [6:0] H_S = 7'b0010010;
    localparam logic [6:0] H_P = 7'b0001100;
    localparam logic [6:0] H_F = 7'b0001110;
    localparam logic [6:0] H_L = 7'b1000111;
    localparam logic [6:0] BL  = 7'b1111111;

`ifdef OCCUPANCY_DISPLAY_EN
    localparam bit SHOW_OCC = 1'b1;
`else
    localparam bit SHOW_OCC = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_WAITP = 1;
    localparam int M_WRONG = 2;
    localparam int M_RIGHT = 3;
    localparam int M_STOP  = 4;
    localparam int M_LOCK  = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       entr = 1'b0, ex = 1'b0, dep = 1'b0;
    logic [1:0] p1 = 2'b00, p2 = 2'b00;
    logic       GREEN_LED, RED_LED, full, lockout;
    logic [6:0] HEX_1, HEX_2;
    logic [6:0] occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    int m_st, m_left, m_tries, m_occ;
    bit m_fl;

    typedef struct {
        logic       e, x, d;
        logic [1:0] a, b;
        logic       g, r;
        logic [6:0] h1, h2;
        int         occ;
        logic       lk;
    } vec_t;
    vec_t vq[$];

    always #5 clk = ~clk;

    parking_gate_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sensor_entrance (entr),
        .sensor_exit     (ex),
        .car_departed    (dep),
        .password_1      (p1),
        .password_2      (p2),
        .GREEN_LED       (GREEN_LED),
        .RED_LED         (RED_LED),
        .HEX_1           (HEX_1),
        .HEX_2           (HEX_2),
        .occupancy       (occupancy),
        .full            (full),
        .lockout         (lockout)
    );

    function automatic logic [6:0] dig(int d);
        logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    function automatic logic [6:0] idle_h1(int occ);
        if (!SHOW_OCC || occ < 10) return BL;
        return dig(occ / 10);
    endfunction

    function automatic logic [6:0] idle_h2(int occ);
        if (!SHOW_OCC) return BL;
        return dig(occ % 10);
    endfunction

    task automatic check(string nm, logic eg, logic er, logic [6:0] eh1, logic [6:0] eh2,
                         int eocc, logic elk);
        logic ef;
        ef = (eocc == CAP);
        n_tests++;
        if ({GREEN_LED, RED_LED, HEX_1, HEX_2, lockout, full} !== {eg, er, eh1, eh2, elk, ef} ||
            occupancy !== 7'(eocc)) begin
            n_fail++;
            $display("FAIL %s: got g=%b r=%b h1=%b h2=%b occ=%0d full=%b lock=%b, want g=%b r=%b h1=%b h2=%b occ=%0d full=%b lock=%b",
                     nm, GREEN_LED, RED_LED, HEX_1, HEX_2, occupancy, full, lockout,
                     eg, er, eh1, eh2, eocc, ef, elk);
        end
    endtask

    task automatic check_val(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_left = 0; m_tries = 0; m_occ = 0; m_fl = 0;
    endtask

    task automatic model_step(logic e, logic x, logic d, logic [1:0] a, logic [1:0] b);
        bit full_now, match;
        int nocc, nst;
        full_now = (m_occ == CAP);
        match    = (a == PW1) && (b == PW2);
        nocc     = m_occ + ((m_st == M_RIGHT && x) ? 1 : 0) - ((d && m_occ > 0) ? 1 : 0);
        nst      = m_st;
        case (m_st)
            M_IDLE: if (e && !full_now) begin nst = M_WAITP; m_left = WAITC; end
            M_WAITP, M_WRONG, M_STOP: begin
                if (m_left > 1) m_left--;
                else if (match) begin nst = M_RIGHT; m_tries = 0; end
                else begin
                    m_tries++;
                    nst    = (m_tries >= TRIES) ? M_LOCK : M_WRONG;
                    m_left = (nst == M_LOCK) ? LOCKC : WAITC;
                end
            end
            M_RIGHT: if (x) begin
                if (!e || nocc == CAP) nst = M_IDLE;
                else begin nst = M_STOP; m_left = WAITC; end
            end
            M_LOCK: begin
                if (m_left > 1) m_left--;
                else begin nst = M_IDLE; m_tries = 0; end
            end
            default: nst = M_IDLE;
        endcase
        m_fl  = (nst == M_IDLE) && e && full_now;
        m_st  = nst;
        m_occ = nocc;
    endtask

    task automatic check_model(string nm);
        logic g, r, lk;
        logic [6:0] h1, h2;
        g = 0; r = 0; lk = 0; h1 = BL; h2 = BL;
        case (m_st)
            M_IDLE:  begin r = m_fl; h1 = m_fl ? H_F : idle_h1(m_occ); h2 = m_fl ? H_L : idle_h2(m_occ); end
            M_WAITP: begin h1 = H_E; h2 = H_N; end
            M_WRONG: begin r = 1; h1 = H_E; h2 = H_E; end
            M_RIGHT: begin g = 1; h1 = H_G; h2 = H_O; end
            M_STOP:  begin r = 1; h1 = H_S; h2 = H_P; end
            default: begin r = 1; lk = 1; h1 = H_L; h2 = H_O; end
        endcase
        check(nm, g, r, h1, h2, m_occ, lk);
    endtask

    task automatic tick(string nm, logic e, logic x, logic d, logic [1:0] a, logic [1:0] b);
        entr = e; ex = x; dep = d; p1 = a; p2 = b;
        @(posedge clk);
        #1;
        model_step(e, x, d, a, b);
        check_model(nm);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        entr = 0; ex = 0; dep = 0; p1 = 0; p2 = 0;
        #1;
        check("reset_async", 0, 0, BL, BL, 0, 0);
        @(posedge clk);
        #1;
        check("reset_hold", 0, 0, BL, BL, 0, 0);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic enter_and_eval(string nm, logic [1:0] a, logic [1:0] b);
        tick({nm, "_ent"}, 1, 0, 0, a, b);
        for (int i = 0; i < WAITC; i++) tick({nm, "_wait"}, 0, 0, 0, a, b);
    endtask

    task automatic admit_car(string nm);
        enter_and_eval(nm, PW1, PW2);
        tick({nm, "_pass"}, 0, 1, 0, PW1, PW2);
    endtask

    task automatic add(logic e, logic x, logic d, logic [1:0] a, logic [1:0] b,
                       logic g, logic r, logic [6:0] h1, logic [6:0] h2, int occ, logic lk);
        vec_t v;
        v.e = e; v.x = x; v.d = d; v.a = a; v.b = b;
        v.g = g; v.r = r; v.h1 = h1; v.h2 = h2; v.occ = occ; v.lk = lk;
        vq.push_back(v);
    endtask

    initial begin
        // Table: correct entry, then three failures into lockout with entrance held.
        add(1, 0, 0, PW1, PW2, 0, 0, H_E, H_N, 0, 0);
        add(0, 0, 0, PW1, PW2, 0, 0, H_E, H_N, 0, 0);
        add(0, 0, 0, PW1, PW2, 0, 0, H_E, H_N, 0, 0);
        add(0, 0, 0, PW1, PW2, 1, 0, H_G, H_O, 0, 0);
        add(0, 0, 0, PW1, PW2, 1, 0, H_G, H_O, 0, 0);
        add(0, 1, 0, PW1, PW2, 0, 0, idle_h1(1), idle_h2(1), 1, 0);
        add(0, 0, 0, PW1, PW2, 0, 0, idle_h1(1), idle_h2(1), 1, 0);
        add(1, 0, 0, 2'b00, 2'b00, 0, 0, H_E, H_N, 1, 0);
        for (int k = 0; k < 2; k++) add(0, 0, 0, 2'b00, 2'b00, 0, 0, H_E, H_N, 1, 0);
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < WAITC; k++) add(0, 0, 0, 2'b00, 2'b00, 0, 1, H_E, H_E, 1, 0);
        add(0, 0, 0, 2'b00, 2'b00, 0, 1, H_L, H_O, 1, 1);
        for (int k = 0; k < LOCKC - 1; k++) add(1, 0, 0, PW1, PW2, 0, 1, H_L, H_O, 1, 1);
        add(1, 0, 0, PW1, PW2, 0, 0, idle_h1(1), idle_h2(1), 1, 0);
        add(0, 0, 0, PW1, PW2, 0, 0, idle_h1(1), idle_h2(1), 1, 0);

        #2;
        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            entr = vq[i].e; ex = vq[i].x; dep = vq[i].d; p1 = vq[i].a; p2 = vq[i].b;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vq[i].g, vq[i].r, vq[i].h1, vq[i].h2, vq[i].occ, vq[i].lk);
        end

        // Wrong once then correct clears the try count.
        do_reset();
        tick("retry_ent", 1, 0, 0, 2'b11, 2'b00);
        for (int k = 0; k < WAITC; k++) tick("retry_w1", 0, 0, 0, 2'b11, 2'b00);
        for (int k = 0; k < WAITC; k++) tick("retry_ok", 0, 0, 0, PW1, PW2);
        check_val("retry_green", int'(GREEN_LED), 1);
        tick("retry_exit", 0, 1, 0, PW1, PW2);
        enter_and_eval("retry_f1", 2'b00, 2'b10);
        for (int k = 0; k < WAITC; k++) tick("retry_f2", 0, 0, 0, 2'b00, 2'b10);
        check_val("retry_no_lock", int'(lockout), 0);
        check_val("retry_wrong_red", int'(RED_LED), 1);
        for (int k = 0; k < WAITC; k++) tick("retry_f3", 0, 0, 0, 2'b00, 2'b10);
        check_val("retry_lock", int'(lockout), 1);
        for (int k = 0; k < LOCKC; k++) tick("retry_lockwait", 0, 0, 0, 2'b00, 2'b00);
        check_val("retry_unlock", int'(lockout), 0);

        // Fill to capacity, refuse entry, then accept after a departure.
        do_reset();
        for (int c = 0; c < CAP; c++) admit_car("fill");
        check_val("fill_full", int'(full), 1);
        check_val("fill_occ", int'(occupancy), CAP);
        for (int k = 0; k < 3; k++) tick("full_refuse", 1, 0, 0, PW1, PW2);
        check_val("full_hex1", int'(HEX_1), int'(H_F));
        check_val("full_hex2", int'(HEX_2), int'(H_L));
        check_val("full_red", int'(RED_LED), 1);
        tick("full_depart", 0, 0, 1, PW1, PW2);
        check_val("full_cleared", int'(full), 0);
        tick("full_accept", 1, 0, 0, PW1, PW2);
        check_val("full_accept_hex", int'(HEX_1), int'(H_E));

        // Back-to-back cars through STOP, and reaching capacity on a tailgate.
        do_reset();
        for (int c = 0; c < 3; c++) admit_car("stop_pre");
        enter_and_eval("stop_a", PW1, PW2);
        tick("stop_tail", 1, 1, 0, PW1, PW2);
        check_val("stop_occ4", int'(occupancy), 4);
        check_val("stop_hex", int'({HEX_1, HEX_2}), int'({H_S, H_P}));
        for (int k = 0; k < WAITC; k++) tick("stop_eval", 0, 0, 0, PW1, PW2);
        check_val("stop_go", int'({HEX_1, HEX_2}), int'({H_G, H_O}));
        tick("stop_exit", 0, 1, 0, PW1, PW2);
        for (int c = 0; c < 2; c++) admit_car("stop_more");
        enter_and_eval("stop_b", PW1, PW2);
        tick("stop_tail_full", 1, 1, 0, PW1, PW2);
        check_val("stop_occ8", int'(occupancy), 8);
        check_val("stop_idle_green", int'(GREEN_LED), 0);
        tick("stop_after_full", 1, 0, 0, PW1, PW2);

        // Occupancy edge cases and reset while the gate is open.
        do_reset();
        tick("dep_at_zero", 0, 0, 1, PW1, PW2);
        check_val("dep_zero_occ", int'(occupancy), 0);
        admit_car("net_a");
        enter_and_eval("net_b", PW1, PW2);
        tick("net_same_cycle", 0, 1, 1, PW1, PW2);
        check_val("net_unchanged", int'(occupancy), 1);
        enter_and_eval("rst_mid", PW1, PW2);
        check_val("rst_mid_green", int'(GREEN_LED), 1);
        do_reset();

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic e, x, d;
            logic [1:0] a, b;
            e = ($urandom_range(0, 9) < 4);
            x = ($urandom_range(0, 9) < 4);
            d = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1) begin
                a = PW1; b = PW2;
            end else begin
                a = 2'($urandom_range(0, 3)); b = 2'($urandom_range(0, 3));
            end
            tick($sformatf("rand%0d", i), e, x, d, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
